// File: rtl/uintm_alu_if.sv
// Request/result handshake bundle for uintm_alu. The master side offers operations and consumes results.
// The slave side is the ALU itself.
interface uintm_alu_if #(
    parameter int BITS = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [BITS-1:0] x;
    logic [BITS-1:0] y;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out;
    logic            err;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, out, err
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, out, err
    );
endinterface

// File: rtl/uintm_alu.sv
// Unsigned BITS-wide ALU with valid/ready handshakes. Bitwise ops and add/sub finish in one edge.
// Multiply is shift-and-add over exactly BITS steps, so its latency does not depend on the operands.
module uintm_alu #(
    parameter int BITS = 8
) (
    input logic         clk,
    input logic         rst_n,
    uintm_alu_if.slave  bus
);
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] out_q, out_d;
    logic            err_q, err_d;
    logic [BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0] mcand_q, mcand_d;
    logic [BITS-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] acc_step;

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                    case (bus.op)
                        3'd0: out_d = bus.x + bus.y;
                        3'd1: out_d = bus.x - bus.y;
                        3'd2: begin
                            acc_d    = '0;
                            mcand_d  = bus.x;
                            mplier_d = bus.y;
                            cnt_d    = '0;
                            state_d  = MUL;
                        end
                        3'd3: out_d = bus.x & bus.y;
                        3'd4: out_d = bus.x | bus.y;
                        3'd5: out_d = bus.x ^ bus.y;
                        default: begin
                            out_d = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // This edge completes the final step, so the result is the updated accumulator.
                if (cnt_q == CW'(BITS - 1)) begin
                    out_d   = acc_step;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uintm_alu.sv
// Self-checking bench for uintm_alu (BITS=8): directed cases plus randomized ops with random backpressure.
// Every result is compared against a plain-arithmetic reference model.
module tb_uintm_alu;
    localparam int BITS = 8;
    localparam int MUL_WAIT = BITS;  // cycles spent in MUL after the accept edge

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    uintm_alu_if #(.BITS(BITS)) bus ();

    uintm_alu #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_out(input int op, input int a, input int b);
        int m = 1 << BITS;
        case (op)
            0: return (a + b) % m;
            1: return (a - b + m) % m;
            2: return (a * b) % m;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, wait for result, optional stall with ignored requests, handoff.
    task automatic run_op(input int op, input int a, input int b, input int stall, input string tag);
        int lat;
        int exp_out;
        int exp_err;
        int exp_lat;
        exp_out = ref_out(op, a, b);
        exp_err = (op > 5) ? 1 : 0;
        exp_lat = (op == 2) ? MUL_WAIT : 0;

        check({tag, ".in_ready_before"}, bus.in_ready, 1);
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.op        = 3'(op);
        bus.x         = BITS'(a);
        bus.y         = BITS'(b);
        tick();
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom_range(0, 7));
        bus.x        = BITS'($urandom);
        bus.y        = BITS'($urandom);

        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            check({tag, ".in_ready_busy"}, bus.in_ready, 0);
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".err"}, bus.err, exp_err);

        for (int s = 0; s < stall; s++) begin
            bus.in_valid = s[0];
            bus.op       = 3'($urandom_range(0, 7));
            bus.x        = BITS'($urandom);
            bus.y        = BITS'($urandom);
            tick();
            check({tag, ".hold_valid"}, bus.out_valid, 1);
            check({tag, ".hold_out"}, bus.out, exp_out);
            check({tag, ".hold_err"}, bus.err, exp_err);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check({tag, ".handoff_valid"}, bus.out_valid, 0);
        check({tag, ".handoff_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.x         = '0;
        bus.y         = '0;
        bus.out_ready = 1'b1;

        #12;
        check("reset.in_ready", bus.in_ready, 1);
        check("reset.out_valid", bus.out_valid, 0);
        check("reset.out", bus.out, 0);
        check("reset.err", bus.err, 0);
        rst_n = 1'b1;

        // First request right after release is taken on the first edge.
        run_op(0, 200, 100, 0, "add_200_100");
        run_op(1, 3, 5, 0, "sub_3_5");
        run_op(5, 8'hF0, 8'hFF, 0, "xor_f0_ff");
        run_op(2, 13, 21, 0, "mul_13_21");
        run_op(2, 255, 255, 0, "mul_255_255");
        run_op(0, 1, 2, 5, "add_backpressure");
        run_op(7, 9, 9, 0, "illegal_7");
        run_op(0, 1, 1, 0, "add_after_illegal");
        run_op(6, 3, 4, 0, "illegal_6");

        // Not buffered: an idle cycle with in_valid low must not produce a result.
        tick();
        check("no_buffer.out_valid", bus.out_valid, 0);

        // Asynchronous reset while the multiply is at step 4.
        bus.in_valid = 1'b1;
        bus.op       = 3'd2;
        bus.x        = 8'd13;
        bus.y        = 8'd21;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("mid_mul.in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid", bus.out_valid, 0);
        check("async_rst.out", bus.out, 0);
        check("async_rst.in_ready", bus.in_ready, 1);
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        begin
            int late = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (bus.out_valid) late++;
            end
            check("no_late_result", late, 0);
        end

        // Reset while a result is waiting for the consumer.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd4;
        bus.x         = 8'h0F;
        bus.y         = 8'h30;
        tick();
        bus.in_valid = 1'b0;
        check("done_pre_rst.out", bus.out, 8'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        check("done_rst.out_valid", bus.out_valid, 0);
        check("done_rst.err", bus.err, 0);
        #4;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("done_rst.after", bus.out_valid, 0);

        for (int i = 0; i < 200; i++) begin
            run_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uintm_alu.md
UINTM_ALU -- requirements
Module: uintm_alu

Interface
REQ-001 SHALL have parameter BITS, default 8, giving operand and result width (BITS >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request offered.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port op  input  3  0=add, 1=sub, 2=mul, 3=and, 4=or, 5=xor, 6/7=illegal.
REQ-007 SHALL have port x  input  BITS  first operand, unsigned.
REQ-008 SHALL have port y  input  BITS  second operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready at a rising edge.
REQ-011 SHALL have port out  output  BITS  result.
REQ-012 SHALL have port err  output  1  result came from an illegal op; qualified by out_valid.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, MUL, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL sample op, x and y only on the accept edge; later changes on these inputs SHALL have no effect on the operation in flight.
REQ-016 On accept of op 0,1,3,4,5: register out = x+y, x-y, x&y, x|y or x^y truncated mod 2^BITS; set err=0; go to DONE; 1-edge latency.
REQ-017 On accept of op 6/7: register out=0, err=1, go to DONE; 1-edge latency.
REQ-018 On accept of op 2: load acc=0, mcand=x, mplier=y, cnt=0; go to MUL.
REQ-019 In MUL, each edge: if mplier[0] then acc += mcand (mod 2^BITS); mcand <<= 1; mplier >>= 1; cnt += 1.
REQ-020 On the edge completing step BITS: out = final acc, err=0, go to DONE; accept-to-out_valid latency exactly BITS edges, independent of operand values.
REQ-021 Multiply result SHALL equal (x*y) mod 2^BITS.
REQ-022 Subtraction SHALL wrap: x<y yields x-y+2^BITS.
REQ-023 In DONE, out and err SHALL stay constant while out_ready=0 (unbounded backpressure).
REQ-024 In DONE with out_ready=1: go to IDLE; in_ready rises the next cycle (no same-edge result/request overlap).
REQ-025 in_valid while not in IDLE SHALL be ignored and not buffered.
REQ-026 cnt SHALL be wide enough for BITS (clog2(BITS+1) bits) and never wrap during MUL.

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force state=IDLE, out=0, err=0, out_valid=0, in_ready=1, acc/mcand/mplier/cnt=0.
REQ-028 Reset asserted mid-MUL or in DONE SHALL discard the operation; no result appears after release.
REQ-029 After rst_n deasserts, the first request SHALL be accepted on the first rising edge at which in_valid=1.

Verification (BITS=8)
REQ-030 add x=200, y=100, out_ready=1 -> out_valid one edge after accept, out=44, err=0, in_ready back the following cycle.
REQ-031 sub x=3, y=5 -> out=254; xor x=0xF0, y=0xFF -> out=0x0F.
REQ-032 mul x=13, y=21 -> in_ready=0 for 8 cycles, out_valid after 8 edges, out=17; mul x=255, y=255 -> out=1.
REQ-033 add x=1, y=2 with out_ready=0 for 5 cycles -> out=3 held stable, in_valid pulses ignored, one handoff when out_ready=1.
REQ-034 mul 13*21, rst_n low asynchronously at step 4 -> out_valid=0, out=0, in_ready=1 immediately; no late result.
REQ-035 op=7 x=9, y=9 -> out=0, err=1 after one edge; next op=0 x=1, y=1 -> out=2, err=0.
